dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 16, byte-address width of all address ports.
REQ-002 Parameter: DATA_W, default 16, word width of all data ports.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: m0_req  input  1  requester 0 (CPU load/store) access request.
REQ-006 Port: m0_we  input  1  requester 0 access type: 1 = write, 0 = read.
REQ-007 Port: m0_addr  input  ADDR_W  requester 0 byte address.
REQ-008 Port: m0_wdata  input  DATA_W  requester 0 write data.
REQ-009 Port: m0_gnt  output  1  requester 0 access accepted this cycle.
REQ-010 Port: m0_rvalid  output  1  requester 0 read response valid.
REQ-011 Port: m0_rdata  output  DATA_W  requester 0 read data.
REQ-012 Port: m0_err  output  1  requester 0 misaligned-access error pulse.
REQ-013 Ports m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata and m1_err SHALL mirror REQ-005..REQ-012 for requester 1 (debug/DMA).
REQ-014 Port: mem_addr  output  ADDR_W  address to data memory.
REQ-015 Port: mem_write_data  output  DATA_W  write data to data memory.
REQ-016 Port: mem_write  output  1  memory write strobe (committed at clk edge).
REQ-017 Port: mem_read  output  1  memory read enable.
REQ-018 Port: mem_read_data  input  DATA_W  asynchronous memory read data.

Function
REQ-019 Handshake: a requester holds req, we, addr and wdata stable until it sees gnt=1; the access completes on the rising edge ending that cycle.
REQ-020 gnt SHALL be combinational from req and the priority pointer; at most one of m0_gnt and m1_gnt SHALL be high in any cycle.
REQ-021 Single request: the requesting port SHALL be granted in the same cycle.
REQ-022 Both requesting: the port other than the one last granted (pointer lp) SHALL win; lp updates to the winner on each grant.
REQ-023 No request: mem_write = mem_read = 0; mem_addr and mem_write_data = 0; lp unchanged.
REQ-024 Granted, aligned (addr[0]=0): mem_addr, mem_write_data, mem_write = we, mem_read = ~we driven from the winner in that cycle.
REQ-025 Granted read: mem_read_data SHALL be captured into the winner's rdata register, and its rvalid SHALL be 1 for exactly the next cycle (read latency 1).
REQ-026 rdata SHALL hold its last captured value while rvalid = 0.
REQ-027 Granted write: no rvalid pulse is generated.
REQ-028 Misaligned grant (addr[0]=1): gnt = 1; mem_write = mem_read = 0; the port's err SHALL pulse for one cycle on the next cycle; rvalid stays 0; lp updates as normal.
REQ-029 Back-to-back: a port may be granted every cycle; a new grant may coincide with the rvalid of its previous read.
REQ-030 Write then read of the same address in consecutive cycles, by either port, SHALL return the newly written data.

Reset
REQ-031 When rst = 1 at a clock edge: lp <= 1 (m0 wins the first contention); m0_rvalid, m1_rvalid, m0_err, m1_err <= 0; m0_rdata, m1_rdata <= 0.
REQ-032 During a cycle with rst = 1, gnt outputs and mem_write, mem_read SHALL be 0; no memory access is issued.
REQ-033 A read granted in the cycle immediately before rst is asserted SHALL NOT produce an rvalid.

Verification
REQ-034 Reset, then m0 writes 0xBEEF at 0x0002 with m1 idle -> m0_gnt = 1 in the same cycle, mem_write = 1, mem_addr = 0x0002; no rvalid.
REQ-035 Next cycle, m1 reads 0x0002 -> m1_gnt = 1; m1_rvalid = 1 one cycle later with m1_rdata = 0xBEEF.
REQ-036 After reset, both ports request reads every cycle for 4 cycles -> grants alternate m0, m1, m0, m1; each port sees rvalid in the cycle after each of its grants.
REQ-037 m0 read at 0x0003 -> m0_gnt = 1, mem_read = 0, m0_err = 1 in the next cycle, m0_rvalid = 0.
REQ-038 m1 read granted, rst asserted in the following cycle -> m1_rvalid stays 0, and after reset the first contention is won by m0.
REQ-039 Random traffic with a reference model -> never both gnt high, every aligned read matches model data, and no requester waits more than 1 cycle under contention.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// ============================================================================
// Module  : dmem_arbiter_if
// Brief   : Bundle of both requester ports and the data-memory port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              m0_req;
   logic              m0_we;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdata;
   logic              m0_gnt;
   logic              m0_rvalid;
   logic [DATA_W-1:0] m0_rdata;
   logic              m0_err;

   logic              m1_req;
   logic              m1_we;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wdata;
   logic              m1_gnt;
   logic              m1_rvalid;
   logic [DATA_W-1:0] m1_rdata;
   logic              m1_err;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_write_data;
   logic              mem_write;
   logic              mem_read;
   logic [DATA_W-1:0] mem_read_data;

   // master is the system side: both requesters plus the memory's read port
   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      output m1_req, m1_we, m1_addr, m1_wdata,
      output mem_read_data,
      input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
      input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
      input  mem_addr, mem_write_data, mem_write, mem_read
   );

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      input  mem_read_data,
      output m0_gnt, m0_rvalid, m0_rdata, m0_err,
      output m1_gnt, m1_rvalid, m1_rdata, m1_err,
      output mem_addr, mem_write_data, mem_write, mem_read
   );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module  : dmem_arbiter
// Brief   : Two-port round-robin arbiter onto a single-cycle data memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  wire logic     clk,
   input  wire logic     rst,
   dmem_arbiter_if.slave bus
);

   logic              lp_q, lp_d;
   logic              m0_rvalid_q, m0_rvalid_d;
   logic              m1_rvalid_q, m1_rvalid_d;
   logic              m0_err_q, m0_err_d;
   logic              m1_err_q, m1_err_d;
   logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
   logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

   logic              w_gnt0, w_gnt1, w_any, w_we, w_mis;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_wdata;

   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (!rst) begin
         // lp_q = 1 means m1 was granted last, so m0 takes the contention
         if (bus.m0_req && bus.m1_req) begin
            w_gnt0 = lp_q;
            w_gnt1 = ~lp_q;
         end else begin
            w_gnt0 = bus.m0_req;
            w_gnt1 = bus.m1_req;
         end
      end
      w_any   = w_gnt0 | w_gnt1;
      w_we    = w_gnt1 ? bus.m1_we    : bus.m0_we;
      w_addr  = w_gnt1 ? bus.m1_addr  : bus.m0_addr;
      w_wdata = w_gnt1 ? bus.m1_wdata : bus.m0_wdata;
      w_mis   = w_addr[0];

      lp_d        = w_any ? w_gnt1 : lp_q;
      m0_rvalid_d = w_gnt0 & ~w_mis & ~w_we;
      m1_rvalid_d = w_gnt1 & ~w_mis & ~w_we;
      m0_err_d    = w_gnt0 & w_mis;
      m1_err_d    = w_gnt1 & w_mis;
      m0_rdata_d  = m0_rvalid_d ? bus.mem_read_data : m0_rdata_q;
      m1_rdata_d  = m1_rvalid_d ? bus.mem_read_data : m1_rdata_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lp_q        <= 1'b1;
         m0_rvalid_q <= 1'b0;
         m1_rvalid_q <= 1'b0;
         m0_err_q    <= 1'b0;
         m1_err_q    <= 1'b0;
         m0_rdata_q  <= '0;
         m1_rdata_q  <= '0;
      end else begin
         lp_q        <= lp_d;
         m0_rvalid_q <= m0_rvalid_d;
         m1_rvalid_q <= m1_rvalid_d;
         m0_err_q    <= m0_err_d;
         m1_err_q    <= m1_err_d;
         m0_rdata_q  <= m0_rdata_d;
         m1_rdata_q  <= m1_rdata_d;
      end
   end

   assign bus.m0_gnt         = w_gnt0;
   assign bus.m1_gnt         = w_gnt1;
   assign bus.mem_addr       = w_any ? w_addr  : '0;
   assign bus.mem_write_data = w_any ? w_wdata : '0;
   assign bus.mem_write      = w_any & ~w_mis & w_we;
   assign bus.mem_read       = w_any & ~w_mis & ~w_we;

   // A read granted just before reset must not surface while reset is held
   assign bus.m0_rvalid = m0_rvalid_q & ~rst;
   assign bus.m1_rvalid = m1_rvalid_q & ~rst;
   assign bus.m0_rdata  = m0_rdata_q;
   assign bus.m1_rdata  = m1_rdata_q;
   assign bus.m0_err    = m0_err_q;
   assign bus.m1_err    = m1_err_q;

endmodule

`default_nettype wire
